scan_cfg_ctrl: RTL and testbench



---
 rtl/scan_cfg_if.sv | 30 +++
 rtl/scan_cfg_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_scan_cfg_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/scan_cfg_if.sv
// Video-stream and recognizer signal bundle for the scan-line configuration controller.
interface scan_cfg_if;
  logic [9:0]  vcnt;
  logic [10:0] hcnt;
  logic        Bit;
  logic [3:0]  number_in;
  logic        number_strobe;
  logic [9:0]  scany1;
  logic [9:0]  scany2;
  logic [10:0] scanx;
  logic [10:0] box_x_min;
  logic [10:0] box_x_max;
  logic [9:0]  box_y_min;
  logic [9:0]  box_y_max;
  logic        cfg_valid;
  logic [3:0]  number_out;
  logic        number_valid;

  modport master (
    output vcnt, hcnt, Bit, number_in, number_strobe,
    input  scany1, scany2, scanx, box_x_min, box_x_max, box_y_min, box_y_max,
           cfg_valid, number_out, number_valid
  );

  modport slave (
    input  vcnt, hcnt, Bit, number_in, number_strobe,
    output scany1, scany2, scanx, box_x_min, box_x_max, box_y_min, box_y_max,
           cfg_valid, number_out, number_valid
  );
endinterface

// File: rtl/scan_cfg_ctrl.sv
// Per-frame bounding-box measurement, scan-line derivation with frame-aligned commit,
// and cross-frame voting on the recognizer result.
module scan_cfg_ctrl #(
  parameter int H_ACT    = 1280,
  parameter int V_ACT    = 720,
  parameter int MIN_W    = 20,
  parameter int MIN_H    = 40,
  parameter int MAX_AREA = 150000,
  parameter int STABLE_N = 3,
  parameter int DEF_Y1   = 310,
  parameter int DEF_Y2   = 443,
  parameter int DEF_X    = 610
) (
  input  logic      clk,
  input  logic      rst_n,
  scan_cfg_if.slave bus
);

  localparam int CW = $clog2(STABLE_N + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_N);

  typedef enum logic [2:0] {IDLE, MEASURE, CHECK, CALC, LOAD, WAIT_COMMIT} state_t;

  state_t      state;
  logic [10:0] x_min, x_max;
  logic [9:0]  y_min, y_max;
  logic        found;

  logic [9:0]  div_n, div_q;
  logic [1:0]  div_rem;
  logic [3:0]  div_cnt;
  logic [2:0]  div_try;
  logic        div_ge;

  logic [9:0]  sh_y1, sh_y2, sh_ymin, sh_ymax;
  logic [10:0] sh_x, sh_xmin, sh_xmax;
  logic        sh_valid;

  logic        fs, wc, pix_fg, box_ok;
  logic [10:0] box_w;
  logic [9:0]  box_h;
  logic [20:0] box_area;

  logic [3:0]    vote_last;
  logic [CW-1:0] vote_cnt, vote_cnt_nxt;
  logic          vote_same;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c >= STABLE_C) ? STABLE_C : c + CW'(1);
  endfunction

  assign fs     = (bus.vcnt == 10'd0) && (bus.hcnt == 11'd0);
  assign wc     = (bus.vcnt == 10'(V_ACT)) && (bus.hcnt == 11'd0);
  assign pix_fg = bus.Bit && (bus.hcnt < 11'(H_ACT)) && (bus.vcnt < 10'(V_ACT));

  assign box_w    = x_max - x_min;
  assign box_h    = y_max - y_min;
  assign box_area = {10'd0, box_w} * {11'd0, box_h};
  assign box_ok   = found && (box_w >= 11'(MIN_W)) && (box_h >= 10'(MIN_H)) &&
                    (box_area <= 21'(MAX_AREA));

  // Restoring divide by 3: remainder stays below 3, so one 3-bit trial per quotient bit
  assign div_try = {div_rem, div_n[9]};
  assign div_ge  = (div_try >= 3'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      x_min         <= '1;
      x_max         <= '0;
      y_min         <= '1;
      y_max         <= '0;
      found         <= 1'b0;
      div_n         <= '0;
      div_q         <= '0;
      div_rem       <= '0;
      div_cnt       <= '0;
      sh_y1         <= 10'(DEF_Y1);
      sh_y2         <= 10'(DEF_Y2);
      sh_x          <= 11'(DEF_X);
      sh_xmin       <= '0;
      sh_xmax       <= '0;
      sh_ymin       <= '0;
      sh_ymax       <= '0;
      sh_valid      <= 1'b0;
      bus.scany1    <= 10'(DEF_Y1);
      bus.scany2    <= 10'(DEF_Y2);
      bus.scanx     <= 11'(DEF_X);
      bus.box_x_min <= '0;
      bus.box_x_max <= '0;
      bus.box_y_min <= '0;
      bus.box_y_max <= '0;
      bus.cfg_valid <= 1'b0;
    end else begin
      // Every frame start begins a fresh measurement, whatever state we are in
      if (fs) begin
        x_min <= '1;
        x_max <= '0;
        y_min <= '1;
        y_max <= '0;
        found <= 1'b0;
      end else if (state == MEASURE && pix_fg) begin
        if (bus.hcnt < x_min) x_min <= bus.hcnt;
        if (bus.hcnt > x_max) x_max <= bus.hcnt;
        if (bus.vcnt < y_min) y_min <= bus.vcnt;
        if (bus.vcnt > y_max) y_max <= bus.vcnt;
        found <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (fs) state <= MEASURE;
        end
        MEASURE: begin
          if (wc) state <= CHECK;
        end
        CHECK: begin
          if (fs) begin
            state <= MEASURE;
          end else if (box_ok) begin
            div_n   <= box_h;
            div_q   <= '0;
            div_rem <= '0;
            div_cnt <= '0;
            state   <= CALC;
          end else begin
            sh_valid <= 1'b0;
            state    <= WAIT_COMMIT;
          end
        end
        CALC: begin
          if (fs) begin
            state <= MEASURE;
          end else begin
            div_n   <= {div_n[8:0], 1'b0};
            div_rem <= div_ge ? 2'(div_try - 3'd3) : div_try[1:0];
            div_q   <= {div_q[8:0], div_ge};
            div_cnt <= div_cnt + 4'd1;
            if (div_cnt == 4'd9) state <= LOAD;
          end
        end
        LOAD: begin
          if (fs) begin
            state <= MEASURE;
          end else begin
            sh_y1    <= y_min + div_q;
            sh_y2    <= y_min + {div_q[8:0], 1'b0};
            sh_x     <= x_min + {1'b0, box_w[10:1]};
            sh_xmin  <= x_min;
            sh_xmax  <= x_max;
            sh_ymin  <= y_min;
            sh_ymax  <= y_max;
            sh_valid <= 1'b1;
            state    <= WAIT_COMMIT;
          end
        end
        WAIT_COMMIT: begin
          if (fs) begin
            bus.scany1    <= sh_y1;
            bus.scany2    <= sh_y2;
            bus.scanx     <= sh_x;
            bus.box_x_min <= sh_xmin;
            bus.box_x_max <= sh_xmax;
            bus.box_y_min <= sh_ymin;
            bus.box_y_max <= sh_ymax;
            bus.cfg_valid <= sh_valid;
            state         <= MEASURE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Voting sees the registered cfg_valid, so a strobe on a commit edge uses the old value
  assign vote_same    = (bus.number_in == vote_last);
  assign vote_cnt_nxt = vote_same ? sat_inc(vote_cnt) : CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_last        <= '0;
      vote_cnt         <= '0;
      bus.number_out   <= '0;
      bus.number_valid <= 1'b0;
    end else if (bus.number_strobe) begin
      if (!bus.cfg_valid) begin
        vote_cnt         <= '0;
        bus.number_valid <= 1'b0;
      end else begin
        vote_cnt <= vote_cnt_nxt;
        if (!vote_same) vote_last <= bus.number_in;
        if (vote_cnt_nxt == STABLE_C) begin
          bus.number_out   <= bus.number_in;
          bus.number_valid <= 1'b1;
        end else if (!vote_same) begin
          bus.number_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_cfg_ctrl.sv
// Directed bench for scan_cfg_ctrl: sparse pixel stimulus drives the counters directly.
module tb_scan_cfg_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  scan_cfg_if bus();

  scan_cfg_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_scan(input string tag, input int y1, input int y2, input int x, input int cv);
    chk({tag, "_y1"}, 32'(bus.scany1), y1);
    chk({tag, "_y2"}, 32'(bus.scany2), y2);
    chk({tag, "_x"},  32'(bus.scanx), x);
    chk({tag, "_cv"}, 32'(bus.cfg_valid), cv);
  endtask

  task automatic chk_box(input string tag, input int x0, input int x1, input int y0, input int y1);
    chk({tag, "_bx0"}, 32'(bus.box_x_min), x0);
    chk({tag, "_bx1"}, 32'(bus.box_x_max), x1);
    chk({tag, "_by0"}, 32'(bus.box_y_min), y0);
    chk({tag, "_by1"}, 32'(bus.box_y_max), y1);
  endtask

  task automatic chk_num(input string tag, input int nout, input int nvld);
    chk({tag, "_nout"}, 32'(bus.number_out), nout);
    chk({tag, "_nvld"}, 32'(bus.number_valid), nvld);
  endtask

  // One clock with the given pixel; returns 1 time unit after the sampling edge
  task automatic pix(input int v, input int h, input logic b);
    bus.vcnt = 10'(v);
    bus.hcnt = 11'(h);
    bus.Bit  = b;
    @(posedge clk);
    #1;
    bus.vcnt          = 10'd1;
    bus.hcnt          = 11'd1;
    bus.Bit           = 1'b0;
    bus.number_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(1, 1, 1'b0);
  endtask

  task automatic strobe(input int n);
    bus.number_in     = 4'(n);
    bus.number_strobe = 1'b1;
    pix(1, 1, 1'b0);
  endtask

  task automatic rect(input int x0, input int x1, input int y0, input int y1);
    pix(y0, x0, 1'b1);
    pix(y0, x1, 1'b1);
    pix((y0 + y1) / 2, (x0 + x1) / 2, 1'b1);
    pix(y1, x0, 1'b1);
    pix(y1, x1, 1'b1);
  endtask

  task automatic close_and_settle();
    pix(720, 0, 1'b0);
    idle(14);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.vcnt          = 10'd1;
    bus.hcnt          = 11'd1;
    bus.Bit           = 1'b0;
    bus.number_in     = 4'd0;
    bus.number_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_scan("rst", 310, 443, 610, 0);
    chk_box("rst", 0, 0, 0, 0);
    chk_num("rst", 0, 0);
    rst_n = 1'b1;
    idle(2);

    // Frame A: first after reset, all black
    pix(0, 0, 1'b0);
    chk_scan("fs1", 310, 443, 610, 0);
    strobe(7);
    chk_num("vote_cfg0", 0, 0);
    idle(3);
    close_and_settle();
    pix(0, 0, 1'b0);
    chk_scan("black", 310, 443, 610, 0);
    chk_box("black", 0, 0, 0, 0);

    // Frame B: rectangle 400..700 x 200..500 plus ignored out-of-window pixels
    rect(400, 700, 200, 500);
    pix(300, 1300, 1'b1);
    pix(10, 1280, 1'b1);
    pix(720, 0, 1'b1);
    idle(11);
    chk("lat11_shy1", 32'(dut.sh_y1), 310);
    idle(1);
    chk("lat12_shy1", 32'(dut.sh_y1), 300);
    chk("lat12_shy2", 32'(dut.sh_y2), 400);
    chk("lat12_shx", 32'(dut.sh_x), 550);
    chk("lat12_shv", 32'(dut.sh_valid), 1);
    chk_scan("preB", 310, 443, 610, 0);
    idle(2);
    pix(0, 0, 1'b0);
    chk_scan("fsB", 300, 400, 550, 1);
    chk_box("fsB", 400, 700, 200, 500);

    // Voting with a valid configuration
    strobe(7);
    chk_num("v7a", 0, 0);
    strobe(7);
    chk_num("v7b", 0, 0);
    strobe(7);
    chk_num("v7c", 7, 1);
    strobe(3);
    chk_num("v3a", 7, 0);
    strobe(3);
    strobe(3);
    chk_num("v3c", 3, 1);

    // Frame C: area too large; strobe on the commit edge uses the pre-commit cfg_valid
    rect(100, 900, 100, 400);
    close_and_settle();
    bus.number_in     = 4'd3;
    bus.number_strobe = 1'b1;
    pix(0, 0, 1'b0);
    chk_scan("area", 300, 400, 550, 0);
    chk_num("fs_vote", 3, 1);
    strobe(5);
    chk_num("v_inval", 3, 0);

    // Frame D: frame start lands five cycles after window close, mid-divide
    rect(100, 200, 50, 150);
    pix(720, 0, 1'b0);
    idle(4);
    pix(0, 0, 1'b0);
    chk("abort_state", 32'(dut.state), 1);
    chk("abort_shv", 32'(dut.sh_valid), 0);
    chk_scan("abort", 300, 400, 550, 0);

    // Frame E: recovery after abort
    rect(100, 200, 50, 150);
    close_and_settle();
    pix(0, 0, 1'b0);
    chk_scan("fsE", 83, 116, 150, 1);
    chk_box("fsE", 100, 200, 50, 150);

    // Frame F: exactly minimum width and height
    rect(10, 30, 10, 50);
    close_and_settle();
    pix(0, 0, 1'b0);
    chk_scan("minwh", 23, 36, 20, 1);

    // Frame G: one pixel too narrow
    rect(10, 29, 10, 50);
    close_and_settle();
    pix(0, 0, 1'b0);
    chk_scan("narrow", 23, 36, 20, 0);

    // Frame H: asynchronous reset mid-measurement
    pix(200, 400, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_scan("arst", 310, 443, 610, 0);
    chk_box("arst", 0, 0, 0, 0);
    chk_num("arst", 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    pix(0, 0, 1'b0);
    chk_scan("rfs1", 310, 443, 610, 0);
    rect(400, 700, 200, 500);
    close_and_settle();
    chk_scan("rpre2", 310, 443, 610, 0);
    pix(0, 0, 1'b0);
    chk_scan("rfs2", 300, 400, 550, 1);
    chk_box("rfs2", 400, 700, 200, 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
